seven_segment_scan_reader: RTL and testbench
============================================

# seven_segment_scan_reader

Recovers the hexadecimal value shown on a multiplexed, active-high seven-segment display by watching its segment and digit-enable lines. Each dwell on a digit is sampled once the lines have settled, and the segment pattern is decoded back to a nibble. A value is published only after it has been seen identically over consecutive complete scans. The block sits on the display-side bus as a monitor and self-check for the team's display drivers; it never drives the display.

## Interface
- DIGITS, 4: number of multiplexed digits (1–8).
- SETTLE_CYCLES, 4: consecutive cycles a digit enable must hold before its segments are sampled (≥1).
- STABLE_SCANS, 2: consecutive identical, error-free frames required before publishing (≥1).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg  in  7  segment lines, active-high, seg[0]=a … seg[6]=g.
- an  in  DIGITS  digit enables, active-high, one-hot when valid; an[0] = least-significant digit.
- value  out  4*DIGITS  last published value; nibble i (value[4i+3:4i]) belongs to an[i].
- valid  out  1  one-cycle pulse when value changes.
- err  out  1  one-cycle pulse when a completed frame contains an undecodable pattern.
- err_mask  out  DIGITS  digits whose pattern was undecodable; updated only with err, held otherwise.

## Operation
- Input stage: seg and an are registered once (seg_q, an_q); all logic uses the registered copies.
- Decode table, seg hex to nibble: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 67→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F. Any other pattern, including 00, is undecodable.
- Dwell counter:
  - Counts consecutive cycles in which an_q is one-hot and equal to the previous an_q.
  - Resets to 1 on any change to a one-hot value.
  - Resets to 0 when an_q is zero or multi-hot; such cycles never sample.
- Capture: on the cycle the dwell count reaches SETTLE_CYCLES, store the decoded nibble and a bad flag in the selected slot and set that slot's captured flag. Capture happens once per dwell, with no further samples until an_q changes.
- Recapture of a slot within a frame overwrites the nibble and bad flag.
- Frame complete: on the capture cycle that makes every captured flag 1. All captured flags clear in that same cycle.
- Frame evaluation, registered on the cycle after completion:
  - Any bad flag set: err=1, err_mask=the bad flags, match count=0, previous-frame-valid=0. value is unchanged.
  - Otherwise, if previous-frame-valid and frame equals the previous frame: match count = min(count+1, STABLE_SCANS-1). If not, match count=0.
  - In both non-error cases, store the frame as the previous frame and set previous-frame-valid=1.
  - Publish when the new match count equals STABLE_SCANS-1 and either the frame differs from value or nothing has yet been published. Publishing loads value and pulses valid for one cycle.
- With STABLE_SCANS=1, every error-free frame that differs from value (or is the first) is published.

## Timing
- Reset values:
  - value=0, valid=0, err=0, err_mask=0.
  - All slots, captured flags, counters, previous frame and published flag cleared.
  - The input registers clear to seg_q=0, an_q=0.
- Sample point: seg is sampled as it was SETTLE_CYCLES cycles after the an edge reached the pins, counting the input register cycle.
- Latency: valid/err are asserted 1 cycle after the frame-completing capture, which is 2 cycles after that capture's pin-level sample.
- valid and err are mutually exclusive and never assert on consecutive cycles from the same frame.
- Asserting rst mid-frame discards partial frames and stability history immediately. Output pulses in flight are dropped.
- Dwell shorter than SETTLE_CYCLES: no capture, and the frame stays incomplete indefinitely until that digit is sampled.

## Test plan
- Reset: assert rst asynchronously mid-scan with valid pending. All outputs must be 0 immediately, and the first frame after release must not publish when STABLE_SCANS=2.
- Steady "1A3F" (defaults): scan an=0001/0010/0100/1000 with seg=71/4F/77/06, 8 cycles per digit.
  - Second frame: valid pulses once and value=16'h1A3F.
  - Third identical frame: no pulse.
- Value change: after "1A3F" is published, scan "0000" (seg=3F on all digits). The first frame must not publish; the second publishes value=16'h0000 with a valid pulse.
- Bad pattern: in one frame drive seg=00 on an=0100. Required: err pulse with err_mask=4'b0100 and value held. The next single good frame must not publish; two good frames do.
- Glitch rejection: hold an=0010 for only 3 cycles, or drive an=0011 for 10 cycles. Neither may capture; the frame completes only after a full 4-cycle dwell on digit 1.
- Overwrite: within one frame, sample digit 0 as 06 and later as 5B before the frame completes. Over two frames, value[3:0]=2 must be published.

Source files
------------

// File: rtl/seven_segment_scan_reader.sv
// Passive monitor: decodes a multiplexed active-high 7-segment display back into hex nibbles.
// value/valid/err land 1 cycle after the frame-completing capture. There is no backpressure; it only observes the bus.
module seven_segment_scan_reader #(
   parameter int DIGITS        = 4,
   parameter int SETTLE_CYCLES = 4,
   parameter int STABLE_SCANS  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   value,
   output logic                  valid,
   output logic                  err,
   output logic [DIGITS-1:0]     err_mask
);

   localparam int CW = $clog2(SETTLE_CYCLES + 2);
   localparam int MW = $clog2(STABLE_SCANS + 1);
   localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] DWELL_SAT = CW'(SETTLE_CYCLES + 1);
   localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_SCANS - 1);

   // Returns {bad, nibble}; bad=1 for any pattern outside the hex font.
   function automatic logic [4:0] decode_seg(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h3F:   r = 5'h00;
         7'h06:   r = 5'h01;
         7'h5B:   r = 5'h02;
         7'h4F:   r = 5'h03;
         7'h66:   r = 5'h04;
         7'h6D:   r = 5'h05;
         7'h7D:   r = 5'h06;
         7'h07:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h67:   r = 5'h09;
         7'h77:   r = 5'h0A;
         7'h7C:   r = 5'h0B;
         7'h39:   r = 5'h0C;
         7'h5E:   r = 5'h0D;
         7'h79:   r = 5'h0E;
         7'h71:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   logic [6:0]          seg_q;
   logic [DIGITS-1:0]   an_q;
   logic [DIGITS-1:0]   an_prev;
   logic [CW-1:0]       dwell_q;
   logic [CW-1:0]       dwell_d;
   logic                an_onehot;
   logic                capture;
   logic                frame_done;
   logic                frame_done_q;
   logic [4:0]          dec;
   logic [4*DIGITS-1:0] frame_nib;
   logic [DIGITS-1:0]   frame_bad;
   logic [DIGITS-1:0]   captured;
   logic [4*DIGITS-1:0] prev_frame;
   logic                prev_vld;
   logic [MW-1:0]       match_q;
   logic [MW-1:0]       match_d;
   logic                published;
   logic                frame_eq;
   logic                any_bad;
   logic                publish;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q   <= '0;
         an_q    <= '0;
         an_prev <= '0;
         dwell_q <= '0;
      end else begin
         seg_q   <= seg;
         an_q    <= an;
         an_prev <= an_q;
         dwell_q <= dwell_d;
      end
   end

   // Dwell saturates one past the settle point so each dwell captures exactly once.
   always_comb begin
      dwell_d   = '0;
      an_onehot = (an_q != '0) && ((an_q & (an_q - DIGITS'(1))) == '0);
      if (an_onehot) begin
         if (an_q == an_prev)
            dwell_d = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + CW'(1);
         else
            dwell_d = CW'(1);
      end
      capture    = an_onehot && (dwell_d == SETTLE_C);
      frame_done = capture && ((captured | an_q) == '1);
      dec        = decode_seg(seg_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_nib    <= '0;
         frame_bad    <= '0;
         captured     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= frame_done;
         for (int i = 0; i < DIGITS; i++) begin
            if (capture && an_q[i]) begin
               frame_nib[4*i +: 4] <= dec[3:0];
               frame_bad[i]        <= dec[4];
            end
         end
         if (frame_done)
            captured <= '0;
         else if (capture)
            captured <= captured | an_q;
      end
   end

   // Evaluation reads the slots as they stood at completion.
   always_comb begin
      any_bad  = |frame_bad;
      frame_eq = prev_vld && (frame_nib == prev_frame);
      match_d  = '0;
      if (frame_eq)
         match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
      publish  = !any_bad && (match_d == MATCH_MAX) &&
                 ((frame_nib != value) || !published);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value      <= '0;
         valid      <= 1'b0;
         err        <= 1'b0;
         err_mask   <= '0;
         prev_frame <= '0;
         prev_vld   <= 1'b0;
         match_q    <= '0;
         published  <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         if (frame_done_q) begin
            if (any_bad) begin
               err      <= 1'b1;
               err_mask <= frame_bad;
               match_q  <= '0;
               prev_vld <= 1'b0;
            end else begin
               match_q    <= match_d;
               prev_frame <= frame_nib;
               prev_vld   <= 1'b1;
               if (publish) begin
                  value     <= frame_nib;
                  valid     <= 1'b1;
                  published <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// Directed bench for seven_segment_scan_reader with default parameters.
module tb_seven_segment_scan_reader;

   localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F;
   localparam logic [6:0] SA = 7'h77, SF = 7'h71, SBAD = 7'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] value;
   logic        valid;
   logic        err;
   logic [3:0]  err_mask;

   int n_checks = 0;
   int n_errors = 0;
   int vcnt = 0;
   int ecnt = 0;

   always #5 clk = ~clk;

   seven_segment_scan_reader dut (
      .clk      (clk),
      .rst      (rst),
      .seg      (seg),
      .an       (an),
      .value    (value),
      .valid    (valid),
      .err      (err),
      .err_mask (err_mask)
   );

   // Pulse counters sampled on the falling edge, away from output updates.
   always @(negedge clk) begin
      if (valid) vcnt++;
      if (err)   ecnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      repeat (n) begin
         @(negedge clk);
         an  = a;
         seg = s;
      end
   endtask

   task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
      drive(4'b0001, s0, 8);
      drive(4'b0010, s1, 8);
      drive(4'b0100, s2, 8);
      drive(4'b1000, s3, 8);
   endtask

   initial begin
      rst = 1'b1;
      an  = '0;
      seg = '0;
      #1;
      check("rst_value", value, 0);
      check("rst_valid", valid, 0);
      check("rst_err", err, 0);
      check("rst_err_mask", err_mask, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Steady "1A3F"
      scan(SF, S3, SA, S1);
      check("steady_f1_vcnt", vcnt, 0);
      scan(SF, S3, SA, S1);
      check("steady_f2_vcnt", vcnt, 1);
      check("steady_f2_value", value, 16'h1A3F);
      scan(SF, S3, SA, S1);
      check("steady_f3_vcnt", vcnt, 1);

      // Change to "0000"
      scan(S0, S0, S0, S0);
      check("chg_f1_vcnt", vcnt, 1);
      check("chg_f1_value", value, 16'h1A3F);
      scan(S0, S0, S0, S0);
      check("chg_f2_vcnt", vcnt, 2);
      check("chg_f2_value", value, 16'h0000);

      // Undecodable pattern on digit 2
      scan(S0, S0, SBAD, S0);
      check("bad_ecnt", ecnt, 1);
      check("bad_err_mask", err_mask, 4'b0100);
      check("bad_value", value, 16'h0000);
      check("bad_vcnt", vcnt, 2);
      scan(SF, S3, SA, S1);
      check("bad_good1_vcnt", vcnt, 2);
      check("bad_mask_held", err_mask, 4'b0100);
      scan(SF, S3, SA, S1);
      check("bad_good2_vcnt", vcnt, 3);
      check("bad_good2_value", value, 16'h1A3F);

      // Glitch rejection: short dwell and multi-hot on digit 1 carry a bad pattern
      scan(S0, S0, S0, S0);
      check("glitch_pre_vcnt", vcnt, 3);
      drive(4'b0001, S0, 8);
      drive(4'b0010, SBAD, 3);
      drive(4'b0011, SBAD, 10);
      drive(4'b0100, S0, 8);
      drive(4'b1000, S0, 8);
      check("glitch_no_err", ecnt, 1);
      check("glitch_incomplete", vcnt, 3);
      drive(4'b0010, S0, 8);
      check("glitch_done_vcnt", vcnt, 4);
      check("glitch_done_value", value, 16'h0000);

      // Overwrite digit 0 within a frame
      drive(4'b0001, S1, 8);
      drive(4'b0010, S0, 8);
      drive(4'b0001, S2, 8);
      drive(4'b0100, S0, 8);
      drive(4'b1000, S0, 8);
      check("ovw_f1_vcnt", vcnt, 4);
      scan(S2, S0, S0, S0);
      check("ovw_f2_vcnt", vcnt, 5);
      check("ovw_f2_value", value, 16'h0002);

      // Reset with a publish one cycle away
      scan(SF, S3, SA, S1);
      check("rst_pre_vcnt", vcnt, 5);
      drive(4'b0001, SF, 8);
      drive(4'b0010, S3, 8);
      drive(4'b0100, SA, 8);
      drive(4'b1000, S1, 1);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_value", value, 0);
      check("midrst_valid", valid, 0);
      check("midrst_err", err, 0);
      check("midrst_err_mask", err_mask, 0);
      repeat (2) @(negedge clk);
      an  = '0;
      seg = '0;
      rst = 1'b0;
      check("midrst_dropped", vcnt, 5);
      scan(SF, S3, SA, S1);
      check("post_rst_f1_vcnt", vcnt, 5);
      check("post_rst_f1_value", value, 16'h0000);
      scan(SF, S3, SA, S1);
      check("post_rst_f2_vcnt", vcnt, 6);
      check("post_rst_f2_value", value, 16'h1A3F);
      check("total_err_pulses", ecnt, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
